// File: rtl/hvac_pkg.sv
// Shared definitions for the HVAC sequencer: state encoding, mode and timer width.
package hvac_pkg;
  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFAN  = 3'd1,
    ST_HEAT    = 3'd2,
    ST_COOL    = 3'd3,
    ST_POSTFAN = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_e;

  typedef enum logic {
    MODE_HEAT = 1'b0,
    MODE_COOL = 1'b1
  } mode_e;

  // Timer is loaded with duration-1 so a state lasts exactly 'd' cycles.
  function automatic logic [TIMER_W-1:0] dur_m1(input int unsigned d);
    return TIMER_W'(d - 1);
  endfunction
endpackage

// File: rtl/hvac_timer.sv
// Loadable down counter that saturates at zero; zero flags the final cycle of a state.
import hvac_pkg::*;

module hvac_timer (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);
  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/hvac_sequencer.sv
// Heat/cool sequencer: pre-purge, minimum on-time, post-purge and lockout with
// registered Moore outputs derived from the next state so they track 'state'.
import hvac_pkg::*;

module hvac_sequencer #(
  parameter int unsigned FAN_PRE  = 4,
  parameter int unsigned MIN_ON   = 10,
  parameter int unsigned FAN_POST = 6,
  parameter int unsigned MIN_OFF  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       heat_req,
  input  logic       cool_req,
  output logic       fan_en,
  output logic       heater_en,
  output logic       compressor_en,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state
);
  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic               tmr_load, tmr_zero;
  logic [TIMER_W-1:0] tmr_val;
  logic               req_on, req_opp;
  logic               fan_q, heater_q, comp_q, busy_q, fault_q;

  hvac_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign req_on  = (mode_q == MODE_HEAT) ? heat_req : cool_req;
  assign req_opp = (mode_q == MODE_HEAT) ? cool_req : heat_req;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (heat_req ^ cool_req) begin
          state_d  = ST_PREFAN;
          mode_d   = heat_req ? MODE_HEAT : MODE_COOL;
          tmr_load = 1'b1;
          tmr_val  = dur_m1(FAN_PRE);
        end
      end
      ST_PREFAN: begin
        if (!req_on) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d  = (mode_q == MODE_HEAT) ? ST_HEAT : ST_COOL;
          tmr_load = 1'b1;
          tmr_val  = dur_m1(MIN_ON);
        end
      end
      ST_HEAT, ST_COOL: begin
        // Demand loss or an opposite request only ends the cycle after MIN_ON.
        if (tmr_zero && (!req_on || req_opp)) begin
          state_d  = ST_POSTFAN;
          tmr_load = 1'b1;
          tmr_val  = dur_m1(FAN_POST);
        end
      end
      ST_POSTFAN: begin
        if (tmr_zero) begin
          state_d  = ST_LOCKOUT;
          tmr_load = 1'b1;
          tmr_val  = dur_m1(MIN_OFF);
        end
      end
      ST_LOCKOUT: begin
        if (tmr_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_HEAT;
      fan_q    <= 1'b0;
      heater_q <= 1'b0;
      comp_q   <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      fan_q    <= (state_d == ST_PREFAN) || (state_d == ST_HEAT) ||
                  (state_d == ST_COOL)   || (state_d == ST_POSTFAN);
      heater_q <= (state_d == ST_HEAT);
      comp_q   <= (state_d == ST_COOL);
      busy_q   <= (state_d != ST_IDLE);
      fault_q  <= heat_req & cool_req;
    end
  end

  assign fan_en        = fan_q;
  assign heater_en     = heater_q;
  assign compressor_en = comp_q;
  assign busy          = busy_q;
  assign fault         = fault_q;
  assign state         = state_q;
endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer at default parameters.
module tb_hvac_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       heat_req = 1'b0;
  logic       cool_req = 1'b0;
  logic       fan_en, heater_en, compressor_en, busy, fault;
  logic [2:0] state;
  int checks = 0;
  int errors = 0;

  hvac_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .heat_req      (heat_req),
    .cool_req      (cool_req),
    .fan_en        (fan_en),
    .heater_en     (heater_en),
    .compressor_en (compressor_en),
    .busy          (busy),
    .fault         (fault),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    heat_req = 1'b0;
    cool_req = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if ({state, fan_en, heater_en, compressor_en, busy, fault} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: got st=%0d fan=%b ht=%b cp=%b busy=%b flt=%b, want all 0",
               state, fan_en, heater_en, compressor_en, busy, fault);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got st=%0d busy=%b, want 0 0", state, busy);
    end
  endtask

  task automatic test_heat_hold();
    do_reset();
    heat_req = 1'b1;
    tick(); // edge 0
    checks++;
    if (state !== 3'd1 || fan_en !== 1'b1 || heater_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prefan_entry: got st=%0d fan=%b ht=%b busy=%b, want 1 1 0 1",
               state, fan_en, heater_en, busy);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (state !== 3'd1 || heater_en !== 1'b0) begin
        errors++;
        $display("FAIL prefan_hold e%0d: got st=%0d ht=%b, want 1 0", i, state, heater_en);
      end
    end
    tick(); // edge 4
    checks++;
    if (state !== 3'd2 || heater_en !== 1'b1 || fan_en !== 1'b1 || compressor_en !== 1'b0) begin
      errors++;
      $display("FAIL heat_entry: got st=%0d ht=%b fan=%b cp=%b, want 2 1 1 0",
               state, heater_en, fan_en, compressor_en);
    end
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (state !== 3'd2 || heater_en !== 1'b1) begin
      errors++;
      $display("FAIL heat_held: got st=%0d ht=%b, want 2 1", state, heater_en);
    end
  endtask

  task automatic test_heat_pulse();
    int n_ht, n_post, n_lock, n_both;
    n_ht = 0; n_post = 0; n_lock = 0; n_both = 0;
    do_reset();
    heat_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 5) heat_req = 1'b0;
      if (heater_en === 1'b1) n_ht++;
      if (state === 3'd4) n_post++;
      if (state === 3'd5) n_lock++;
      if (heater_en === 1'b1 && compressor_en === 1'b1) n_both++;
    end
    checks++;
    if (n_ht != 10) begin
      errors++;
      $display("FAIL pulse_min_on: got %0d heater cycles, want 10", n_ht);
    end
    checks++;
    if (n_post != 6) begin
      errors++;
      $display("FAIL pulse_postfan: got %0d cycles, want 6", n_post);
    end
    checks++;
    if (n_lock != 8) begin
      errors++;
      $display("FAIL pulse_lockout: got %0d cycles, want 8", n_lock);
    end
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || fan_en !== 1'b0 || n_both != 0) begin
      errors++;
      $display("FAIL pulse_end: got st=%0d busy=%b fan=%b both=%0d, want 0 0 0 0",
               state, busy, fan_en, n_both);
    end
  endtask

  task automatic test_fault();
    do_reset();
    heat_req = 1'b1;
    cool_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (state !== 3'd0 || fault !== 1'b1 || fan_en !== 1'b0 || heater_en !== 1'b0 ||
          compressor_en !== 1'b0) begin
        errors++;
        $display("FAIL fault_idle c%0d: got st=%0d flt=%b fan=%b ht=%b cp=%b, want 0 1 0 0 0",
                 i, state, fault, fan_en, heater_en, compressor_en);
      end
    end
    heat_req = 1'b0;
    cool_req = 1'b0;
    tick();
    checks++;
    if (fault !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL fault_clear: got flt=%b st=%0d, want 0 0", fault, state);
    end
  endtask

  task automatic test_changeover();
    int gap, n_post, n_lock;
    bit rose;
    gap = 0; n_post = 0; n_lock = 0; rose = 0;
    do_reset();
    cool_req = 1'b1;
    for (int i = 0; i < 17; i++) tick(); // COOL from edge 4, past MIN_ON
    checks++;
    if (state !== 3'd3 || compressor_en !== 1'b1 || heater_en !== 1'b0) begin
      errors++;
      $display("FAIL cool_on: got st=%0d cp=%b ht=%b, want 3 1 0", state, compressor_en, heater_en);
    end
    cool_req = 1'b0;
    heat_req = 1'b1;
    tick();
    checks++;
    if (compressor_en !== 1'b0 || state !== 3'd4) begin
      errors++;
      $display("FAIL cool_off: got cp=%b st=%0d, want 0 4", compressor_en, state);
    end
    for (int i = 0; i < 60 && !rose; i++) begin
      if (heater_en === 1'b1) rose = 1;
      else begin
        gap++;
        if (state === 3'd4) n_post++;
        if (state === 3'd5) n_lock++;
        tick();
      end
    end
    checks++;
    if (!rose || gap < 18) begin
      errors++;
      $display("FAIL changeover_gap: got rose=%b gap=%0d, want rose=1 gap>=18", rose, gap);
    end
    checks++;
    if (n_post != 6 || n_lock != 8) begin
      errors++;
      $display("FAIL changeover_path: got post=%0d lock=%0d, want 6 8", n_post, n_lock);
    end
  endtask

  task automatic test_prefan_abort();
    do_reset();
    cool_req = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL abort_prefan: got st=%0d, want 1", state);
    end
    cool_req = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || fan_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got st=%0d busy=%b fan=%b, want 0 0 0", state, busy, fan_en);
    end
    cool_req = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1 || fan_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_reaccept: got st=%0d fan=%b, want 1 1", state, fan_en);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    heat_req = 1'b1;
    for (int i = 0; i < 7; i++) tick(); // HEAT after edges 4,5,6
    checks++;
    if (state !== 3'd2 || heater_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_heat: got st=%0d ht=%b, want 2 1", state, heater_en);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || heater_en !== 1'b0 || fan_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got st=%0d ht=%b fan=%b busy=%b, want 0 0 0 0",
               state, heater_en, fan_en, busy);
    end
    tick();
    #2 reset = 1'b0;
    tick();
    checks++;
    if (state !== 3'd1 || fan_en !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_edge: got st=%0d fan=%b, want 1 1", state, fan_en);
    end
  endtask

  initial begin
    test_reset();
    test_heat_hold();
    test_heat_pulse();
    test_fault();
    test_changeover();
    test_prefan_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hvac_sequencer.md
HVAC_SEQUENCER -- requirements
Module: hvac_sequencer

Interface
REQ-001 Parameter FAN_PRE, default 4: fan pre-purge cycles before heat/cool output; legal range 1..65535.
REQ-002 Parameter MIN_ON, default 10: minimum heater/compressor on-time in cycles; legal range 1..65535.
REQ-003 Parameter FAN_POST, default 6: fan post-purge cycles after heat/cool output drops; legal range 1..65535.
REQ-004 Parameter MIN_OFF, default 8: lockout cycles after post-purge before any new request is accepted; legal range 1..65535.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 heat_req  input  1  heating demand from the thermostat comparator.
REQ-008 cool_req  input  1  cooling demand from the thermostat comparator.
REQ-009 fan_en  output  1  blower enable.
REQ-010 heater_en  output  1  heating element enable.
REQ-011 compressor_en  output  1  cooling compressor enable.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 fault  output  1  high in any cycle following an edge at which heat_req and cool_req were both high.
REQ-014 state  output  3  current FSM state code.

Function
REQ-015 The FSM SHALL have states IDLE=0, PREFAN=1, HEAT=2, COOL=3, POSTFAN=4, LOCKOUT=5; codes 6 and 7 SHALL return to IDLE on the next edge.
REQ-016 The timer SHALL be a 16-bit down counter, loaded with (duration-1) on entry to PREFAN, HEAT, COOL, POSTFAN or LOCKOUT, and SHALL decrement each cycle until it reaches 0, then hold at 0.
REQ-017 IDLE: exactly one of heat_req/cool_req high -> PREFAN, latching the mode (heat or cool); both high or both low -> stay in IDLE.
REQ-018 PREFAN: if the latched request drops -> IDLE (no lockout); else at timer==0 -> HEAT or COOL per the latched mode.
REQ-019 PREFAN SHALL last exactly FAN_PRE cycles when the request is held.
REQ-020 HEAT/COOL: exit to POSTFAN only when timer==0 and (the latched request is low or the opposite request is high); the on-state SHALL last at least MIN_ON cycles.
REQ-021 POSTFAN SHALL last exactly FAN_POST cycles, then go to LOCKOUT; requests are ignored.
REQ-022 LOCKOUT SHALL last exactly MIN_OFF cycles, then go to IDLE; requests are ignored.
REQ-023 Outputs SHALL be registered Moore outputs, consistent with the state output in the same cycle.
REQ-024 fan_en=1 in PREFAN, HEAT, COOL and POSTFAN; heater_en=1 only in HEAT; compressor_en=1 only in COOL.
REQ-025 heater_en and compressor_en SHALL never be high in the same cycle.
REQ-026 Any heat-to-cool or cool-to-heat changeover SHALL pass through POSTFAN and LOCKOUT, giving at least FAN_POST+MIN_OFF+FAN_PRE cycles with both enables low.
REQ-027 fault SHALL be asserted in every state; it SHALL NOT be sticky and SHALL NOT alter FSM transitions beyond REQ-017 and REQ-020.

Reset
REQ-028 Reset SHALL immediately force state=IDLE, timer=0 and latched mode=heat, and SHALL drive fan_en, heater_en, compressor_en, busy and fault to 0, independent of clk.
REQ-029 Reset asserted mid-operation (for example in HEAT) SHALL drop all enables at once with no post-purge or lockout.
REQ-030 After reset deasserts, the first edge SHALL evaluate REQ-017 normally.

Structure
REQ-031 Package hvac_pkg SHALL hold the state encoding enum and the TIMER_W=16 constant.
REQ-032 The down counter SHALL be a sub-module hvac_timer (ports: clk, reset, load, load_val, zero); the FSM and output registers SHALL reside in hvac_sequencer.

Verification (default parameters; edge 0 is the first edge at which the request is sampled)
REQ-033 heat_req held high from edge 0 -> PREFAN with fan_en=1 after edge 0 -> HEAT with heater_en=1 after edge 4 -> heater_en held while the request is held.
REQ-034 heat_req high for 6 cycles only -> heater_en high for exactly 10 cycles -> 6 POSTFAN cycles -> 8 LOCKOUT cycles -> IDLE with busy=0.
REQ-035 heat_req and cool_req both high in IDLE for 5 cycles -> state stays IDLE, fault=1 for 5 cycles, all enables 0.
REQ-036 In COOL beyond MIN_ON, cool_req drops and heat_req rises together -> compressor_en falls -> 6+8+4=18 cycles with both enables low -> heater_en rises.
REQ-037 cool_req drops during PREFAN -> IDLE on the next edge with no LOCKOUT; a new request is accepted on the following edge.
REQ-038 reset pulsed in the 3rd cycle of HEAT -> heater_en and fan_en go low before the next edge, state=0.
